// File: rtl/aes_key_schedule_iter.sv
// aes_key_schedule_iter: iterative AES-128/192/256 key expansion, one word per clock, registered round-key read port.
// Define AES_KEYSCHED_INV_EN to add rd_inv, returning InvMixColumns'd round keys for the equivalent inverse cipher.
package aes_pkg;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [0:15][7:0] RCON = 128'h0001020408102040801b360000000000;
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  // Rows of the InvMixColumns matrix {0e 0b 0d 09} built from repeated doubling.
  function automatic logic [31:0] inv_mix(input logic [31:0] w);
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    for (int j = 0; j < 4; j++) begin
      a[j] = w[31-8*j -: 8];
      m9[j] = xt(xt(xt(a[j]))) ^ a[j];
      mb[j] = xt(xt(xt(a[j]))) ^ xt(a[j]) ^ a[j];
      md[j] = xt(xt(xt(a[j]))) ^ xt(xt(a[j])) ^ a[j];
      me[j] = xt(xt(xt(a[j]))) ^ xt(xt(a[j])) ^ xt(a[j]);
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
endpackage

module aes_key_schedule_iter #(
  parameter int NK_MAX = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            key_size,
  input  logic [32*NK_MAX-1:0]  key,
  input  logic [3:0]            rd_round,
`ifdef AES_KEYSCHED_INV_EN
  input  logic                  rd_inv,
`endif
  output logic                  ready,
  output logic                  key_valid,
  output logic [3:0]            nr,
  output logic [127:0]          rd_data
);
  import aes_pkg::*;
  localparam int WORDS = 4*(NK_MAX+7);
  localparam int IW = $clog2(WORDS);
  localparam logic [1:0] IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [3:0] nk_q, nk_d, nr_q, nr_d, rc_q, rc_d, nk_sel;
  logic [IW-1:0] i_q, i_d, rd_idx;
  logic [2:0] p_q, p_d;
  logic [31:0] store_q [WORDS];
  logic [31:0] t, wk, new_w;
  logic [127:0] rd_data_q, rd_data_d, rk;
  logic accept, legal;
  assign ready = state_q != EXPAND;
  assign key_valid = state_q == DONE;
  assign nr = nr_q;
  assign rd_data = rd_data_q;
  always_comb begin
    nk_sel = key_size == 2'd0 ? 4'd4 : key_size == 2'd1 ? 4'd6 : 4'd8;
    legal = key_size != 2'd3 && nk_sel <= 4'(NK_MAX);
    accept = start && ready && legal;
    t = store_q[i_q - IW'(1)];
    wk = store_q[i_q - IW'(nk_q)];
    new_w = p_q == 3'd0 ? wk ^ sub_word(rot_word(t)) ^ {RCON[rc_q], 24'h0} :
            (nk_q == 4'd8 && p_q == 3'd4) ? wk ^ sub_word(t) : wk ^ t;
    state_d = state_q;
    nk_d = nk_q;
    nr_d = nr_q;
    i_d = i_q;
    p_d = p_q;
    rc_d = rc_q;
    if (accept) begin
      state_d = EXPAND;
      nk_d = nk_sel;
      nr_d = nk_sel + 4'd6;
      i_d = IW'(nk_sel);
      p_d = 3'd0;
      rc_d = 4'd1;
    end else if (state_q == EXPAND) begin
      i_d = i_q + IW'(1);
      p_d = {1'b0, p_q} == nk_q - 4'd1 ? 3'd0 : p_q + 3'd1;
      rc_d = p_q == 3'd0 ? rc_q + 4'd1 : rc_q;
      state_d = i_q == IW'({nr_q, 2'b11}) ? DONE : EXPAND;
    end
  end
  always_comb begin
    rd_idx = IW'({rd_round, 2'b00});
    rk = {store_q[rd_idx + IW'(3)], store_q[rd_idx + IW'(2)], store_q[rd_idx + IW'(1)], store_q[rd_idx]};
`ifdef AES_KEYSCHED_INV_EN
    rd_data_d = rd_round > nr_q ? '0 :
                (rd_inv && rd_round != 4'd0 && rd_round < nr_q) ?
                {inv_mix(rk[127:96]), inv_mix(rk[95:64]), inv_mix(rk[63:32]), inv_mix(rk[31:0])} : rk;
`else
    rd_data_d = rd_round > nr_q ? '0 : rk;
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      nk_q <= 4'd4;
      nr_q <= 4'd0;
      i_q <= '0;
      p_q <= 3'd0;
      rc_q <= 4'd1;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      nk_q <= nk_d;
      nr_q <= nr_d;
      i_q <= i_d;
      p_q <= p_d;
      rc_q <= rc_d;
      rd_data_q <= rd_data_d;
    end
  end
  // The word store carries no reset; its contents only matter once written.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < NK_MAX; j++)
        if (j < int'(nk_sel)) store_q[j] <= key[32*j +: 32];
    end else if (state_q == EXPAND) begin
      store_q[i_q] <= new_w;
    end
  end
endmodule

// File: tb/tb_aes_key_schedule_iter.sv
// tb_aes_key_schedule_iter: directed FIPS-197 vectors for the iterative AES key schedule.
module tb_aes_key_schedule_iter;
  logic clk = 0, reset = 1, start = 0;
  logic [1:0] key_size = 0;
  logic [255:0] key = 0;
  logic [3:0] rd_round = 0, nr;
  logic ready, key_valid;
  logic [127:0] rd_data;
`ifdef AES_KEYSCHED_INV_EN
  logic rd_inv = 0;
`endif
  int checks = 0, errors = 0;
  localparam logic [255:0] K128 = {128'h0, 32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
  localparam logic [255:0] K192 = {64'h0, 32'h522c6b7b, 32'h62f8ead2, 32'h809079e5, 32'hc810f32b, 32'hda0e6452, 32'h8e73b0f7};
  localparam logic [255:0] K256 = {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
                                   32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};
  localparam logic [127:0] R128_1  = {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17};
  localparam logic [127:0] R128_10 = {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};
  localparam logic [127:0] R192_12 = {32'h01002202, 32'h8ecc7204, 32'h448c773c, 32'he98ba06f};
  localparam logic [127:0] R256_14 = {32'h706c631e, 32'h046df344, 32'he6188d0b, 32'hfe4890d1};

  always #5 clk = ~clk;

  aes_key_schedule_iter #(.NK_MAX(8)) dut (
    .clk(clk), .reset(reset), .start(start), .key_size(key_size), .key(key),
    .rd_round(rd_round),
`ifdef AES_KEYSCHED_INV_EN
    .rd_inv(rd_inv),
`endif
    .ready(ready), .key_valid(key_valid), .nr(nr), .rd_data(rd_data));

  task automatic run_key(input logic [1:0] ks, input logic [255:0] k, input int pulse_at, output int cycles);
    @(negedge clk);
    start = 1; key_size = ks; key = k;
    @(posedge clk); #1;
    start = 0;
    checks++;
    if (key_valid !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL accept_ks%0d: key_valid=%b ready=%b, required 0 0", ks, key_valid, ready);
    end
    cycles = 0;
    while (cycles < 100) begin
      if (cycles == pulse_at) begin start = 1; key_size = 2'd2; key = K256; end
      else start = 0;
      @(posedge clk); cycles++; #1;
      if (key_valid) break;
    end
    start = 0;
  endtask

  task automatic rd(input logic [3:0] r, output logic [127:0] d);
    @(negedge clk);
    rd_round = r;
    @(posedge clk); #1;
    d = rd_data;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (ready !== 1'b1 || key_valid !== 1'b0 || nr !== 4'd0 || rd_data !== 128'h0) begin
      errors++;
      $display("FAIL reset: ready=%b key_valid=%b nr=%0d rd_data=%h, required 1 0 0 0", ready, key_valid, nr, rd_data);
    end
    @(negedge clk); reset = 0;
  endtask

  task automatic test_aes128;
    int c; logic [127:0] d;
    run_key(2'd0, K128, -1, c);
    checks++;
    if (c !== 40) begin errors++; $display("FAIL aes128_latency: got %0d cycles, required 40", c); end
    checks++;
    if (nr !== 4'd10 || ready !== 1'b1) begin errors++; $display("FAIL aes128_nr: nr=%0d ready=%b, required 10 1", nr, ready); end
    rd(4'd10, d);
    checks++;
    if (d !== R128_10) begin errors++; $display("FAIL aes128_r10: got %h, required %h", d, R128_10); end
    rd(4'd1, d);
    checks++;
    if (d !== R128_1) begin errors++; $display("FAIL aes128_r1: got %h, required %h", d, R128_1); end
  endtask

  task automatic test_aes192;
    int c; logic [127:0] d;
    run_key(2'd1, K192, -1, c);
    checks++;
    if (c !== 46) begin errors++; $display("FAIL aes192_latency: got %0d cycles, required 46", c); end
    checks++;
    if (nr !== 4'd12) begin errors++; $display("FAIL aes192_nr: got %0d, required 12", nr); end
    rd(4'd12, d);
    checks++;
    if (d !== R192_12) begin errors++; $display("FAIL aes192_r12: got %h, required %h", d, R192_12); end
    rd(4'd13, d);
    checks++;
    if (d !== 128'h0) begin errors++; $display("FAIL aes192_r13: got %h, required 0", d); end
  endtask

  task automatic test_aes256;
    int c; logic [127:0] d;
    run_key(2'd2, K256, -1, c);
    checks++;
    if (c !== 52) begin errors++; $display("FAIL aes256_latency: got %0d cycles, required 52", c); end
    rd(4'd14, d);
    checks++;
    if (d !== R256_14) begin errors++; $display("FAIL aes256_r14: got %h, required %h", d, R256_14); end
    rd(4'd0, d);
    checks++;
    if (d !== K256[127:0]) begin errors++; $display("FAIL aes256_r0: got %h, required %h", d, K256[127:0]); end
  endtask

  task automatic test_start_ignored;
    int c; logic [127:0] d;
    run_key(2'd0, K128, 10, c);
    checks++;
    if (c !== 40 || nr !== 4'd10) begin errors++; $display("FAIL busy_start: cycles=%0d nr=%0d, required 40 10", c, nr); end
    rd(4'd10, d);
    checks++;
    if (d !== R128_10) begin errors++; $display("FAIL busy_start_r10: got %h, required %h", d, R128_10); end
    run_key(2'd2, K256, -1, c);
    checks++;
    if (c !== 52 || nr !== 4'd14) begin errors++; $display("FAIL done_restart: cycles=%0d nr=%0d, required 52 14", c, nr); end
    rd(4'd14, d);
    checks++;
    if (d !== R256_14) begin errors++; $display("FAIL done_restart_r14: got %h, required %h", d, R256_14); end
    @(negedge clk);
    start = 1; key_size = 2'd3; key = K128;
    @(posedge clk); #1;
    start = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (key_valid !== 1'b1 || ready !== 1'b1 || nr !== 4'd14) begin
      errors++;
      $display("FAIL illegal_ks: key_valid=%b ready=%b nr=%0d, required 1 1 14", key_valid, ready, nr);
    end
    rd(4'd14, d);
    checks++;
    if (d !== R256_14) begin errors++; $display("FAIL illegal_ks_r14: got %h, required %h", d, R256_14); end
  endtask

  task automatic test_reset_mid;
    int c; logic [127:0] d;
    @(negedge clk);
    start = 1; key_size = 2'd1; key = K192;
    @(posedge clk); #1;
    start = 0;
    repeat (20) @(posedge clk);
    #3 reset = 1;
    #1;
    checks++;
    if (ready !== 1'b1 || key_valid !== 1'b0 || nr !== 4'd0 || rd_data !== 128'h0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b key_valid=%b nr=%0d rd_data=%h, required 1 0 0 0", ready, key_valid, nr, rd_data);
    end
    @(negedge clk); reset = 0;
    run_key(2'd0, K128, -1, c);
    checks++;
    if (c !== 40) begin errors++; $display("FAIL reset_mid_latency: got %0d cycles, required 40", c); end
    rd(4'd10, d);
    checks++;
    if (d !== R128_10) begin errors++; $display("FAIL reset_mid_r10: got %h, required %h", d, R128_10); end
  endtask

`ifdef AES_KEYSCHED_INV_EN
  function automatic logic [7:0] gx(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] r, p;
    r = 0; p = b;
    for (int j = 0; j < 4; j++) begin
      if (c[j]) r = r ^ p;
      p = gx(p);
    end
    return r;
  endfunction
  function automatic logic [31:0] imc(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gm(a0,14)^gm(a1,11)^gm(a2,13)^gm(a3,9), gm(a0,9)^gm(a1,14)^gm(a2,11)^gm(a3,13),
            gm(a0,13)^gm(a1,9)^gm(a2,14)^gm(a3,11), gm(a0,11)^gm(a1,13)^gm(a2,9)^gm(a3,14)};
  endfunction
  task automatic test_inv;
    logic [127:0] f, d, e;
    rd_inv = 0;
    rd(4'd5, f);
    rd_inv = 1;
    rd(4'd5, d);
    e = {imc(f[127:96]), imc(f[95:64]), imc(f[63:32]), imc(f[31:0])};
    checks++;
    if (d !== e) begin errors++; $display("FAIL inv_r5: got %h, required %h", d, e); end
    rd(4'd0, d);
    checks++;
    if (d !== K128[127:0]) begin errors++; $display("FAIL inv_r0: got %h, required %h", d, K128[127:0]); end
    rd(4'd10, d);
    checks++;
    if (d !== R128_10) begin errors++; $display("FAIL inv_r10: got %h, required %h", d, R128_10); end
    rd_inv = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_start_ignored();
    test_reset_mid();
`ifdef AES_KEYSCHED_INV_EN
    test_inv();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
